// File: rtl/ddr4_phy_v2_2_1_byte_drv_pkg.sv
// ---------------------------------------------------------------------------
// ddr4_phy_v2_2_1_byte_drv_pkg
// Shared definitions for the DDR4 byte-lane driver/capture engine.
//   - Lane indices inside the 13-lane IOB byte group
//   - Write FSM state encoding
// ---------------------------------------------------------------------------
package ddr4_phy_v2_2_1_byte_drv_pkg;

  localparam int NUM_LANES  = 13;
  localparam int LANE_DM    = 8;
  localparam int LANE_DQS_T = 9;
  localparam int LANE_DQS_C = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    POST = 2'd3
  } wr_state_t;

endpackage

// File: rtl/ddr4_phy_v2_2_1_byte_rd_cap.sv
// ---------------------------------------------------------------------------
// ddr4_phy_v2_2_1_byte_rd_cap
// Read capture engine for one byte lane: accepts a one-cycle rd_en, opens
// the ODT window, samples BURST_LEN DQ beats, publishes the burst with a
// one-cycle rd_valid and holds ODT for ODT_TRAIL more cycles.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   rd_en       start-capture request (one-cycle pulse)
//   wr_block    write path owns the lane this cycle (rd_en must be refused)
//   dq_in       DQ lanes from the IOB
//   rd_data     last completed burst, beat i = rd_data[i*8+:8]
//   rd_valid    one-cycle pulse with a new rd_data
//   rd_err      one-cycle pulse: the previous cycle's rd_en was refused
//   odt_on      registered ODT enable for the DQ/DM/DQS lanes
//   busy_next   engine will be capturing or trailing next cycle (lets the
//               write path register wr_ready without a cycle of lag)
// ---------------------------------------------------------------------------
module ddr4_phy_v2_2_1_byte_rd_cap
  import ddr4_phy_v2_2_1_byte_drv_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int ODT_TRAIL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_en,
  input  logic                   wr_block,
  input  logic [7:0]             dq_in,
  output logic [BURST_LEN*8-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   rd_err,
  output logic                   odt_on,
  output logic                   busy_next
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LEN - 1);
  localparam logic [1:0]    TRAIL_INIT = 2'((ODT_TRAIL > 0) ? ODT_TRAIL - 1 : 0);

  logic                   cap_reg, cap_next;
  logic                   trail_reg, trail_next;
  logic [BW-1:0]          beat_reg, beat_next;
  logic [1:0]             trail_cnt_reg, trail_cnt_next;
  logic [BURST_LEN*8-1:0] buf_reg, buf_next;
  logic [BURST_LEN*8-1:0] rd_data_reg, rd_data_next;
  logic                   rd_valid_reg, rd_valid_next;
  logic                   rd_err_reg, rd_err_next;
  logic                   odt_reg;
  logic                   rd_accept;

  assign rd_accept = rd_en && !wr_block && !cap_reg && !trail_reg;

  always_comb begin
    cap_next       = cap_reg;
    trail_next     = trail_reg;
    beat_next      = beat_reg;
    trail_cnt_next = trail_cnt_reg;
    buf_next       = buf_reg;
    rd_data_next   = rd_data_reg;
    rd_valid_next  = 1'b0;
    rd_err_next    = rd_en && !rd_accept;

    if (rd_accept) begin
      cap_next  = 1'b1;
      beat_next = '0;
    end

    if (cap_reg) begin
      buf_next[int'(beat_reg)*8 +: 8] = dq_in;
      if (beat_reg == LAST_BEAT) begin
        // Last beat goes straight into rd_data so rd_valid lines up with it.
        cap_next      = 1'b0;
        rd_data_next  = buf_next;
        rd_valid_next = 1'b1;
        if (ODT_TRAIL > 0) begin
          trail_next     = 1'b1;
          trail_cnt_next = TRAIL_INIT;
        end
      end else begin
        beat_next = beat_reg + 1'b1;
      end
    end

    if (trail_reg) begin
      if (trail_cnt_reg == 2'd0) begin
        trail_next = 1'b0;
      end else begin
        trail_cnt_next = trail_cnt_reg - 2'd1;
      end
    end

    busy_next = cap_next || trail_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_reg       <= 1'b0;
      trail_reg     <= 1'b0;
      beat_reg      <= '0;
      trail_cnt_reg <= 2'd0;
      buf_reg       <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      rd_err_reg    <= 1'b0;
      odt_reg       <= 1'b0;
    end else begin
      cap_reg       <= cap_next;
      trail_reg     <= trail_next;
      beat_reg      <= beat_next;
      trail_cnt_reg <= trail_cnt_next;
      buf_reg       <= buf_next;
      rd_data_reg   <= rd_data_next;
      rd_valid_reg  <= rd_valid_next;
      rd_err_reg    <= rd_err_next;
      odt_reg       <= busy_next;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_err   = rd_err_reg;
  assign odt_on   = odt_reg;

endmodule

// File: rtl/ddr4_phy_v2_2_1_byte_drv.sv
// ---------------------------------------------------------------------------
// ddr4_phy_v2_2_1_byte_drv
// PHY-side driver/capture engine for one 13-lane DDR4 byte IOB group
// (one beat per clk). Write path serializes a burst onto DQ/DM with DQS
// preamble/postamble framing; read path (ddr4_phy_v2_2_1_byte_rd_cap)
// captures a burst from d_in under an ODT window.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   wr_valid/wr_ready     write burst handshake
//   wr_data, wr_mask      burst payload (beat i = wr_data[i*8+:8], wr_mask[i])
//   rd_en                 start read capture (one-cycle pulse)
//   rd_data, rd_valid     captured burst and its one-cycle strobe
//   rd_err                one-cycle pulse: rd_en refused
//   q_out, odt_out, t_out to IOB (t = 1 tristates the lane)
//   d_in                  from IOB
// Lane map: [7:0] DQ, [8] DM, [9] DQS_T, [10] DQS_C, [12:11] unused.
// ---------------------------------------------------------------------------
module ddr4_phy_v2_2_1_byte_drv
  import ddr4_phy_v2_2_1_byte_drv_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int PREAMBLE  = 1,
  parameter int POSTAMBLE = 1,
  parameter int ODT_TRAIL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [BURST_LEN*8-1:0] wr_data,
  input  logic [BURST_LEN-1:0]   wr_mask,
  input  logic                   rd_en,
  output logic [BURST_LEN*8-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   rd_err,
  output logic [12:0]            q_out,
  output logic [12:0]            odt_out,
  output logic [12:0]            t_out,
  input  logic [12:0]            d_in
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic          PRE_LAST  = 1'(PREAMBLE - 1);
  localparam logic          POST_LAST = 1'(POSTAMBLE - 1);

  generate
    if (BURST_LEN < 2 || BURST_LEN > 16 || (BURST_LEN % 2) != 0) begin : g_bad_burst_len
      $error("BURST_LEN must be even and within 2..16");
    end
    if (PREAMBLE < 1 || PREAMBLE > 2) begin : g_bad_preamble
      $error("PREAMBLE must be within 1..2");
    end
    if (POSTAMBLE < 1 || POSTAMBLE > 2) begin : g_bad_postamble
      $error("POSTAMBLE must be within 1..2");
    end
    if (ODT_TRAIL < 0 || ODT_TRAIL > 3) begin : g_bad_odt_trail
      $error("ODT_TRAIL must be within 0..3");
    end
  endgenerate

  wr_state_t              state_reg, state_next;
  logic [BW-1:0]          beat_reg, beat_next;
  logic                   phase_reg, phase_next;
  logic [BURST_LEN*8-1:0] data_reg, data_next;
  logic [BURST_LEN-1:0]   mask_reg, mask_next;
  logic                   wr_ready_reg, wr_ready_next;
  logic [12:0]            q_reg, q_next;
  logic [12:0]            t_reg, t_next;
  logic                   wr_fire;
  logic                   rd_block;
  logic                   rd_busy_next;
  logic                   odt_on;
  logic                   unused_d_in;

  assign wr_fire  = wr_valid && wr_ready_reg;
  // A write in flight, or one being accepted this cycle, takes the lane.
  assign rd_block = (state_reg != IDLE) || wr_fire;

  // Write FSM next state
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    phase_next = phase_reg;
    data_next  = data_reg;
    mask_next  = mask_reg;
    case (state_reg)
      IDLE: begin
        if (wr_fire) begin
          state_next = PRE;
          phase_next = 1'b0;
          data_next  = wr_data;
          mask_next  = wr_mask;
        end
      end
      PRE: begin
        if (phase_reg == PRE_LAST) begin
          state_next = DATA;
          beat_next  = '0;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      DATA: begin
        if (beat_reg == LAST_BEAT) begin
          if (wr_fire) begin
            // Seamless: next burst starts at beat 0, DQS keeps toggling.
            beat_next = '0;
            data_next = wr_data;
            mask_next = wr_mask;
          end else begin
            state_next = POST;
            phase_next = 1'b0;
          end
        end else begin
          beat_next = beat_reg + 1'b1;
        end
      end
      POST: begin
        if (phase_reg == POST_LAST) begin
          state_next = IDLE;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pad drive is computed from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    q_next = '0;
    t_next = '1;
    case (state_next)
      PRE, POST: begin
        t_next[LANE_DQS_C:LANE_DQS_T] = 2'b00;
        q_next[LANE_DQS_C]            = 1'b1;
      end
      DATA: begin
        t_next[LANE_DQS_C:0] = '0;
        q_next[7:0]          = data_next[int'(beat_next)*8 +: 8];
        q_next[LANE_DM]      = mask_next[beat_next];
        q_next[LANE_DQS_T]   = ~beat_next[0];
        q_next[LANE_DQS_C]   = beat_next[0];
      end
      default: ;
    endcase
    wr_ready_next = ((state_next == IDLE) && !rd_busy_next) ||
                    ((state_next == DATA) && (beat_next == LAST_BEAT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      phase_reg    <= 1'b0;
      data_reg     <= '0;
      mask_reg     <= '0;
      wr_ready_reg <= 1'b0;
      q_reg        <= '0;
      t_reg        <= '1;
    end else begin
      state_reg    <= state_next;
      beat_reg     <= beat_next;
      phase_reg    <= phase_next;
      data_reg     <= data_next;
      mask_reg     <= mask_next;
      wr_ready_reg <= wr_ready_next;
      q_reg        <= q_next;
      t_reg        <= t_next;
    end
  end

  ddr4_phy_v2_2_1_byte_rd_cap #(
    .BURST_LEN (BURST_LEN),
    .ODT_TRAIL (ODT_TRAIL)
  ) u_rd_cap (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .wr_block  (rd_block),
    .dq_in     (d_in[7:0]),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .odt_on    (odt_on),
    .busy_next (rd_busy_next)
  );

  // Only DQ is captured; DM/DQS/spare inputs are not used by this engine.
  assign unused_d_in = ^d_in[12:8];

  assign wr_ready = wr_ready_reg;
  assign q_out    = q_reg;
  assign t_out    = t_reg;
  assign odt_out  = {2'b00, {11{odt_on}}};

endmodule

// File: tb/tb_ddr4_phy_v2_2_1_byte_drv.sv
module tb_ddr4_phy_v2_2_1_byte_drv;

  localparam int BL = 8;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [BL*8-1:0] wr_data = '0;
  logic [BL-1:0] wr_mask  = '0;
  logic          rd_en    = 1'b0;
  logic [BL*8-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;
  logic [12:0]   q_out;
  logic [12:0]   odt_out;
  logic [12:0]   t_out;
  logic [12:0]   d_in     = '0;

  always #5 clk = ~clk;

  ddr4_phy_v2_2_1_byte_drv #(
    .BURST_LEN (BL),
    .PREAMBLE  (1),
    .POSTAMBLE (1),
    .ODT_TRAIL (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_err   (rd_err),
    .q_out    (q_out),
    .odt_out  (odt_out),
    .t_out    (t_out),
    .d_in     (d_in)
  );

  typedef struct {
    logic        wv;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic        re;
    logic [12:0] din;
    logic [12:0] eq;
    logic [12:0] et;
    logic [12:0] eodt;
    logic        erdy;
    logic        evld;
    logic        eerr;
    logic [63:0] erd;
  } vec_t;

  localparam logic [63:0] D1  = 64'h0807060504030201;
  localparam logic [63:0] D2  = 64'hF0E0D0C0B0A09080;
  localparam logic [63:0] D3  = 64'h3837363534333231;
  localparam logic [7:0]  M3  = 8'h42;
  localparam logic [63:0] PAT = 64'h5AA55AA55AA55AA5;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t idle_row();
    vec_t v;
    v.wv = 1'b0; v.wd = '0; v.wm = '0; v.re = 1'b0; v.din = '0;
    v.eq = 13'h0000; v.et = 13'h1FFF; v.eodt = 13'h0000;
    v.erdy = 1'b1; v.evld = 1'b0; v.eerr = 1'b0; v.erd = '0;
    return v;
  endfunction

  // DQS driven low (DQS_C high), DQ/DM tristated
  function automatic vec_t frame_row();
    vec_t v;
    v = idle_row();
    v.eq = 13'h0400; v.et = 13'h19FF; v.erdy = 1'b0;
    return v;
  endfunction

  function automatic vec_t data_row(input int b, input logic [63:0] d, input logic [7:0] m);
    vec_t v;
    logic [63:0] dd;
    v  = idle_row();
    dd = d;
    v.eq        = {5'b00000, dd[b*8 +: 8]};
    v.eq[8]     = m[b];
    v.eq[9]     = (b % 2 == 0);
    v.eq[10]    = (b % 2 == 1);
    v.et        = 13'h1800;
    v.erdy      = (b == BL - 1);
    return v;
  endfunction

  task automatic build_table();
    vec_t v;
    // Single burst D1, mask 0; rd_en during beat 3 is refused.
    v = idle_row(); v.wv = 1'b1; v.wd = D1; tbl.push_back(v);
    tbl.push_back(frame_row());
    for (int b = 0; b < BL; b++) begin
      v = data_row(b, D1, 8'h00);
      if (b == 3) v.re = 1'b1;
      if (b == 4) v.eerr = 1'b1;
      tbl.push_back(v);
    end
    tbl.push_back(frame_row());
    tbl.push_back(idle_row());
    // Burst D2 with mask 0x81, simultaneous rd_en loses to the write.
    v = idle_row(); v.wv = 1'b1; v.wd = D2; v.wm = 8'h81; v.re = 1'b1; tbl.push_back(v);
    v = frame_row(); v.eerr = 1'b1; tbl.push_back(v);
    for (int b = 0; b < BL; b++) tbl.push_back(data_row(b, D2, 8'h81));
    tbl.push_back(frame_row());
    tbl.push_back(idle_row());
    // Back-to-back: wr_valid held, second burst taken on the last beat.
    v = idle_row(); v.wv = 1'b1; v.wd = D1; tbl.push_back(v);
    v = frame_row(); v.wv = 1'b1; v.wd = D3; v.wm = M3; tbl.push_back(v);
    for (int b = 0; b < BL; b++) begin
      v = data_row(b, D1, 8'h00); v.wv = 1'b1; v.wd = D3; v.wm = M3;
      tbl.push_back(v);
    end
    for (int b = 0; b < BL; b++) tbl.push_back(data_row(b, D3, M3));
    tbl.push_back(frame_row());
    tbl.push_back(idle_row());
    // Read capture of A5/5A pattern; rd_en during capture is refused.
    v = idle_row(); v.re = 1'b1; tbl.push_back(v);
    for (int b = 0; b < BL; b++) begin
      v = idle_row(); v.erdy = 1'b0; v.eodt = 13'h07FF;
      v.din = (b % 2 == 0) ? 13'h00A5 : 13'h005A;
      if (b == 2) v.re = 1'b1;
      if (b == 3) v.eerr = 1'b1;
      tbl.push_back(v);
    end
    v = idle_row(); v.erdy = 1'b0; v.eodt = 13'h07FF; v.evld = 1'b1; v.erd = PAT; tbl.push_back(v);
    v = idle_row(); v.erd = PAT; tbl.push_back(v);
  endtask

  initial begin
    int pulses;
    int lat;

    build_table();

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset q_out", q_out, 13'h0000);
    chk("reset t_out", t_out, 13'h1FFF);
    chk("reset odt_out", odt_out, 13'h0000);
    chk("reset wr_ready", wr_ready, 1'b0);
    chk("reset rd_valid", rd_valid, 1'b0);
    chk("reset rd_err", rd_err, 1'b0);
    chk("reset rd_data", rd_data, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("v%0d q_out", i), q_out, tbl[i].eq);
      chk($sformatf("v%0d t_out", i), t_out, tbl[i].et);
      chk($sformatf("v%0d odt_out", i), odt_out, tbl[i].eodt);
      chk($sformatf("v%0d wr_ready", i), wr_ready, tbl[i].erdy);
      chk($sformatf("v%0d rd_valid", i), rd_valid, tbl[i].evld);
      chk($sformatf("v%0d rd_err", i), rd_err, tbl[i].eerr);
      chk($sformatf("v%0d rd_data", i), rd_data, tbl[i].erd);
      $display("vec %0d: wv=%b re=%b din=%h | q=%h t=%h odt=%h rdy=%b vld=%b err=%b",
               i, tbl[i].wv, tbl[i].re, tbl[i].din, q_out, t_out, odt_out,
               wr_ready, rd_valid, rd_err);
      wr_valid = tbl[i].wv;
      wr_data  = tbl[i].wd;
      wr_mask  = tbl[i].wm;
      rd_en    = tbl[i].re;
      d_in     = tbl[i].din;
    end

    // Reset asserted on write beat 3
    @(negedge clk);
    chk("h1 ready", wr_ready, 1'b1);
    wr_valid = 1'b1; wr_data = D2; wr_mask = 8'h00;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("h1 pre t_out", t_out, 13'h19FF);
    repeat (4) @(negedge clk);
    chk("h1 beat3 q_out", q_out, 13'h04B0);
    rst_n = 1'b0;
    #1;
    chk("h1 rst t_out", t_out, 13'h1FFF);
    chk("h1 rst q_out", q_out, 13'h0000);
    chk("h1 rst wr_ready", wr_ready, 1'b0);
    @(negedge clk);
    chk("h1 next t_out", t_out, 13'h1FFF);
    chk("h1 next wr_ready", wr_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("h1 release wr_ready", wr_ready, 1'b1);
    chk("h1 release t_out", t_out, 13'h1FFF);
    @(negedge clk);
    chk("h1 no resume q_out", q_out, 13'h0000);
    $display("seq h1: reset mid-write done");

    // Reset during capture discards the partial burst
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; d_in = 13'h00FF;
    chk("h2 odt open", odt_out, 13'h07FF);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("h2 rst odt", odt_out, 13'h0000);
    chk("h2 rst rd_data", rd_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1; d_in = '0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rd_valid) pulses++;
    end
    chk("h2 no rd_valid", pulses, 0);
    chk("h2 odt closed", odt_out, 13'h0000);
    $display("seq h2: reset mid-capture done");

    // Read latency and payload, bounded wait for rd_valid
    rd_en = 1'b1;
    lat = 0; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rd_en = 1'b0;
      if (rd_valid) begin
        pulses++;
        if (lat == 0) lat = k;
      end
      d_in = (k <= BL) ? 13'(8'h10 + k - 1) : 13'h0000;
    end
    chk("h3 rd latency", lat, 9);
    chk("h3 rd_valid count", pulses, 1);
    chk("h3 rd_data", rd_data, 64'h1716151413121110);
    $display("seq h3: read latency=%0d data=%h", lat, rd_data);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
